// File: rtl/serial_tx7.sv
// serial_tx7: framed parallel-to-serial transmitter for 7-bit words.
// Frame = start(0), 7 data bits LSB-first, even parity, stop(1); each bit
// lasts CLKS_PER_BIT clocks. tx/ready/done are all registered.
module serial_tx7 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] din,
  input  logic       enable,
  output logic       ready,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             load;

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic; tx is computed for the state being entered so the
  // registered output lines up exactly with the bit window.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        cnt_d   = '0;
        bit_d   = '0;
        load    = enable;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[6:1]};
          if (bit_q == 3'd6) begin
            state_d = S_PARITY;
            bit_d   = '0;
            tx_d    = parity_q;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Frame ends here: done pulses even if the next frame chains in.
          state_d = S_IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          done_d  = 1'b1;
          load    = enable;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
    // Accepted load overrides the above: latch word and parity, start bit now.
    if (load) begin
      state_d  = S_START;
      shift_d  = din;
      parity_d = ^din;
      cnt_d    = '0;
      bit_d    = '0;
      tx_d     = 1'b0;
      ready_d  = 1'b0;
    end
  end

  // State and output registers with asynchronous reset to the idle line state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx7.sv
// Self-checking bench for serial_tx7: directed frames plus random words,
// compared against a frame-level model of the serial line.
module tb_serial_tx7;

  localparam int C = 4;
  localparam int FRAME = 10 * C;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] din;
  logic       ready;
  logic       tx;
  logic       done;

  int checks   = 0;
  int failures = 0;

  serial_tx7 #(.CLKS_PER_BIT(C)) dut (
    .clock (clock),
    .reset (reset),
    .din   (din),
    .enable(enable),
    .ready (ready),
    .tx    (tx),
    .done  (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Line level of bit slot idx (0..9) of the frame carrying word w.
  function automatic logic frame_bit(input logic [6:0] w, input int idx);
    int ones;
    ones = 0;
    for (int k = 0; k < 7; k++) ones += w[k];
    if (idx == 0) return 1'b0;
    if (idx <= 7) return w[idx-1];
    if (idx == 8) return (ones % 2 == 1);
    return 1'b1;
  endfunction

  // Called just after the accepting edge. Checks ncyc cycles of the frame;
  // for a full frame it finishes just after edge N+10C. busy_at>=0 pulses a
  // rejected load with a different word at that cycle.
  task automatic frame_body(input logic [6:0] w, input int ncyc, input int busy_at);
    for (int i = 0; i < ncyc; i++) begin
      check($sformatf("tx[%0d]", i), 32'(tx), 32'(frame_bit(w, i / C)));
      check("ready_busy", 32'(ready), 32'(1'b0));
      if (i > 0) check("done_busy", 32'(done), 32'(1'b0));
      if (i == busy_at) begin
        enable = 1'b1;
        din    = 7'h55;
      end else if (busy_at >= 0 && i == busy_at + 1) begin
        enable = 1'b0;
        din    = 7'($urandom);
      end
      if (i + 1 < ncyc || ncyc == FRAME) step();
    end
  endtask

  // Load w with a one-cycle enable and check the first cycle.
  task automatic start_frame(input logic [6:0] w);
    din    = w;
    enable = 1'b1;
    step();
    enable = 1'b0;
    din    = 7'($urandom);
    check("done_first", 32'(done), 32'(1'b0));
  endtask

  task automatic check_end_idle();
    check("done_end", 32'(done), 32'(1'b1));
    check("ready_end", 32'(ready), 32'(1'b1));
    check("tx_end", 32'(tx), 32'(1'b1));
    step();
    check("done_drop", 32'(done), 32'(1'b0));
    check("ready_idle", 32'(ready), 32'(1'b1));
    check("tx_idle", 32'(tx), 32'(1'b1));
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_tx"}, 32'(tx), 32'(1'b1));
    check({tag, "_ready"}, 32'(ready), 32'(1'b1));
    check({tag, "_done"}, 32'(done), 32'(1'b0));
  endtask

  // Hold reset over an edge with enable high, release between edges, load w.
  task automatic release_and_load(input logic [6:0] w);
    din    = w;
    enable = 1'b1;
    step();
    check("rst_hold_ready", 32'(ready), 32'(1'b1));
    check("rst_hold_tx", 32'(tx), 32'(1'b1));
    #2 reset = 1'b0;
    step();
    enable = 1'b0;
    check("reload_done", 32'(done), 32'(1'b0));
    frame_body(w, FRAME, -1);
    check_end_idle();
  endtask

  initial begin
    logic [6:0] w;
    int gap;
    reset  = 1'b1;
    enable = 1'b0;
    din    = '0;
    #12;
    check("rst_tx", 32'(tx), 32'(1'b1));
    check("rst_ready", 32'(ready), 32'(1'b1));
    check("rst_done", 32'(done), 32'(1'b0));
    reset = 1'b0;
    step();
    check("idle_ready", 32'(ready), 32'(1'b1));

    // Single frame and odd-parity frame.
    start_frame(7'b1010011);
    frame_body(7'b1010011, FRAME, -1);
    check_end_idle();
    start_frame(7'b0000111);
    frame_body(7'b0000111, FRAME, -1);
    check_end_idle();

    // Rejected load while busy; no second frame afterwards.
    start_frame(7'h2A);
    frame_body(7'h2A, FRAME, 12);
    check_end_idle();
    for (int i = 0; i < 2 * C; i++) begin
      step();
      check("no_second_tx", 32'(tx), 32'(1'b1));
      check("no_second_ready", 32'(ready), 32'(1'b1));
    end

    // Back-to-back with enable held: 7F then 00.
    din    = 7'h7F;
    enable = 1'b1;
    step();
    din = 7'h00;
    frame_body(7'h7F, FRAME, -1);
    check("b2b_done", 32'(done), 32'(1'b1));
    check("b2b_tx", 32'(tx), 32'(1'b0));
    check("b2b_ready", 32'(ready), 32'(1'b0));
    enable = 1'b0;
    frame_body(7'h00, FRAME, -1);
    check_end_idle();

    // Reset in idle right on the done cycle, then reset mid-DATA.
    start_frame(7'h33);
    frame_body(7'h33, FRAME, -1);
    check("pre_rst_done", 32'(done), 32'(1'b1));
    async_reset_check("rst_idle");
    release_and_load(7'h4C);
    start_frame(7'h5A);
    frame_body(7'h5A, 3 * C + 2, -1);
    async_reset_check("rst_data");
    release_and_load(7'h01);

    // Reset during PARITY, then clean reload of 7'h01.
    start_frame(7'h6B);
    frame_body(7'h6B, 8 * C + 1, -1);
    async_reset_check("rst_parity");
    release_and_load(7'h01);

    // Random words with random idle gaps.
    for (int n = 0; n < 8; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        check("gap_tx", 32'(tx), 32'(1'b1));
        check("gap_ready", 32'(ready), 32'(1'b1));
        check("gap_done", 32'(done), 32'(1'b0));
      end
      w = 7'($urandom);
      start_frame(w);
      frame_body(w, FRAME, -1);
      check_end_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx7.md
# serial_tx7

Parallel-to-serial transmitter for 7-bit words, sitting downstream of the 7-bit holding register. It accepts a word on a load handshake and drives it onto a single wire as a framed serial stream: start bit, 7 data bits LSB-first, even parity, stop bit. It is the send side of the 7-bit word path; a matching receiver reassembles the word and loads it into a register at the far end.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  7  word to transmit; sampled only on an accepted load.
- enable  input  1  load request; a load is accepted when enable=1 and ready=1 at a rising edge.
- ready  output  1  1 when idle and able to accept a load.
- tx  output  1  serial line; idles high.
- done  output  1  one-cycle pulse marking the end of a frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: state=IDLE, tx=1, ready=1, done=0, shift register=0, bit counter=0, cycle counter=0.
- IDLE: tx=1, ready=1.
  - On an accepted load:
    - latch din into the shift register;
    - compute parity = XOR of din bits (even parity: total ones over data+parity is even);
    - go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - 7 bits total, tracked by a 3-bit counter 0..6; after bit 6, go to PARITY.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with done=1 for exactly that first IDLE cycle.
- ready=0 in every state except IDLE.
- enable while ready=0 is ignored; no queuing. din changes after acceptance do not affect the frame in flight.
- Cycle counter: width ceil(log2(CLKS_PER_BIT)). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- tx, ready and done are registered outputs, with no combinational path from inputs.

## Timing
- Load accepted at rising edge N:
  - tx=0 and ready=0 are visible from edge N.
  - Start bit covers cycles N..N+C-1, where C=CLKS_PER_BIT.
  - Data bit k covers N+(k+1)C .. N+(k+2)C-1.
  - Parity bit covers N+8C .. N+9C-1.
  - Stop bit covers N+9C .. N+10C-1.
- At edge N+10C: ready=1 and done=1; done returns to 0 at edge N+10C+1.
- Frame length is exactly 10·C cycles.
- Back-to-back: enable=1 held at edge N+10C starts the next frame at that edge. The new start bit begins at N+10C with no idle gap, and done still pulses in that cycle.
- Reset asserted mid-frame: immediately, without waiting for a clock, tx=1, ready=1, done=0, state=IDLE. The partial frame is abandoned. The first load is accepted at the first rising edge after reset deasserts.
- enable and reset released together: no load is accepted at the reset-release edge if reset is still high at that edge.

## Test plan
- Reset check: assert reset mid-idle and mid-DATA -> tx=1, ready=1, done=0 within the same cycle, before the next clock edge.
- Single frame: C=4, din=7'b1010011, one-cycle enable -> tx per bit = 0,1,1,0,0,1,0,1,0,1, each held 4 cycles (40 cycles total); done pulses once at cycle 40; ready low for cycles 0–39.
- Odd-parity data: din=7'b0000111 -> parity bit=1; frame 0,1,1,1,0,0,0,0,1,1.
- Ignore while busy: enable pulsed with din=7'h55 at cycle 12 of a frame carrying 7'h2A -> the frame still carries 7'h2A, and no second frame follows.
- Back-to-back: enable held high with din=7'h7F, then 7'h00 -> second start bit begins exactly at cycle 40 with no idle cycle; parity 1 for 7'h7F, parity 0 for 7'h00.
- Reset mid-frame then reload: reset during the PARITY bit, release, load 7'h01 -> clean new frame 0,1,0,0,0,0,0,0,1,1 with no residue from the aborted word.
